p6_fetch_branch_ctrl: RTL and testbench
=======================================

Name: p6_fetch_branch_ctrl

Overview:
- Instruction-fetch and control-flow sequencer for the Simple RISC Machine CPU.
- Owns the PC and instruction register, and drives memory read commands.
- Resolves B/BEQ/BNE/BLT/BLE/BL/BX/BLX and HALT locally, using the datapath's N/V/Z flags and register read port.
- Hands every other opcode to the execute FSM via an exec_start/exec_done handshake.

Parameters:
- PC_W, 9, PC and memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; overrides every other input.
- s  in  1  start; sampled only in WAIT.
- mem_rdata  in  16  instruction word from memory.
- mem_ready  in  1  mem_rdata valid; sampled only in IF2.
- N, V, Z  in  1  datapath status flags.
- rd_val  in  16  combinational register-file read data for readnum.
- exec_done  in  1  execute FSM finished; sampled only in EXEC.
- mem_cmd  out  2  00 none, 01 read.
- mem_addr  out  PC_W  fetch address (= pc).
- load_ir  out  1  one-cycle pulse when the instruction register loads.
- instruction  out  16  instruction register.
- pc  out  PC_W  program counter.
- readnum  out  3  register-file read select.
- link_write  out  1  write enable for the R7 link write.
- writenum  out  3  write select; 3'd7 during link, else 0.
- link_data  out  16  zero-extended pc during link.
- exec_start  out  1  one-cycle pulse handing the instruction to the execute FSM.
- w  out  1  high only in WAIT.
- halted  out  1  high only in HALT.

Behaviour:
- Reset (reset==0 at an edge), including mid-operation:
  - state=WAIT, pc=RESET_PC, instruction=0.
  - All outputs 0 except w=1.
  - A pending memory read or execute handshake is abandoned.
- States: WAIT, IF1, IF2, UPDATE_PC, DECODE, BRANCH, LINK, BX, EXEC, HALT.
- WAIT: w=1. Go to IF1 when s=1, else stay.
- IF1: mem_cmd=01, mem_addr=pc. Go to IF2.
- IF2: mem_cmd=01 held.
  - mem_ready=1: load_ir=1, instruction<=mem_rdata, go to UPDATE_PC.
  - mem_ready=0: stay in IF2, no timeout.
- UPDATE_PC: pc<=pc+1 mod 2^PC_W. Go to DECODE.
- DECODE, with op=instruction[15:13] and sub=instruction[12:11]:
  - op 001 -> BRANCH.
  - op 010 with sub 11 (BL) -> LINK.
  - op 010 with sub 10 (BLX) -> LINK.
  - op 010 with sub 00 (BX) -> BX.
  - op 010 with sub 01 -> IF1 (NOP).
  - op 111 -> HALT.
  - Any other op -> EXEC, with exec_start=1 in this DECODE cycle only.
- BRANCH: cond=instruction[10:8].
  - Taken condition: 000 always; 001 Z; 010 !Z; 011 N^V; 100 (N^V)|Z; 101–111 never.
  - Taken: pc<=pc+sximm8, where sximm8 is instruction[7:0] sign-extended and the sum is truncated to PC_W bits (wraps).
  - Go to IF1.
- LINK: link_write=1, writenum=7, link_data={zeros,pc}.
  - BL: pc<=pc+sximm8.
  - BLX: readnum=instruction[7:5], pc<=rd_val[PC_W-1:0]. Read happens in the same cycle as the write, so the old R7 is used when Rd=R7.
  - Go to IF1.
- BX: readnum=instruction[7:5], pc<=rd_val[PC_W-1:0]. Go to IF1.
- EXEC: hold instruction and pc.
  - exec_done=1: go to IF1.
  - exec_done=0: stay.
- HALT: halted=1. Stay until reset; s, mem_ready and exec_done are ignored.
- Latencies:
  - Fetch: minimum 3 cycles from IF1 to DECODE.
  - Branch/BX/BL/BLX: 1 cycle after DECODE, then the next IF1.
- Flags N/V/Z are sampled combinationally in BRANCH; the block never latches them.
- Out-of-state inputs: exec_done, mem_ready and s are ignored outside EXEC, IF2 and WAIT respectively.
- Defaults: readnum, writenum, link_data, mem_cmd and all pulses are 0 in states not listed above.

Test Plan:
- Reset and start: hold reset=0 for 2 cycles -> pc=0, w=1, mem_cmd=00, instruction=0. Set s=1 -> next cycle mem_cmd=01, mem_addr=0, w=0.
- Fetch stall plus execute handoff: delay mem_ready 3 cycles, mem_rdata=16'hA0E1 -> load_ir pulses once, pc 0->1, exec_start pulses once. Hold exec_done=0 for 5 cycles -> stays in EXEC. exec_done=1 -> IF1 with mem_addr=1.
- Conditional branch: fetch 16'h21FE (BEQ, offset -2) at pc=5 -> pc=6 after UPDATE_PC.
  - Z=1 -> pc=4.
  - Z=0 -> pc=6.
  - Same word with PC_W=9 at pc=511 -> pc=0 after UPDATE_PC; Z=1 -> pc=510.
- Condition decode: BLT 16'h2303 with N=1, V=0 -> taken (pc+3). With N=1, V=1 -> not taken. BLE 16'h2403 with Z=1, N=V -> taken.
- Link paths:
  - BL 16'h5F04 at pc=10 -> LINK: link_write=1 for 1 cycle, writenum=7, link_data=11, then pc=15.
  - BLX 16'h57E0 with rd_val=16'h0020 -> link_data=old pc, pc=0x20.
  - BX 16'h4040 with rd_val=16'h0033 -> pc=0x33, link_write=0.
- Halt and reset mid-operation:
  - Fetch 16'hE000 -> halted=1, mem_cmd stays 00, toggling s has no effect.
  - reset=0 while stalled in IF2 -> next cycle WAIT, pc=0, mem_cmd=00, load_ir never pulses.

Source files
------------

// File: rtl/p6_fetch_branch_ctrl.sv
// Fetch and control-flow sequencer for the Simple RISC Machine.
// Owns PC and instruction register, issues memory reads, resolves
// branches / links / BX / HALT locally and hands every other opcode to
// the execute FSM.
//
// Handshakes:
//   Memory: mem_cmd=01 is the request (valid), held from IF1 through IF2;
//   mem_ready is the response and is looked at only in IF2. The word is
//   taken on the edge where mem_ready=1, with no timeout.
//   Execute: exec_start is a one-cycle pulse in DECODE; exec_done is
//   looked at only in EXEC and releases the sequencer back to IF1.
//   Reset (active low) abandons either handshake at once.
module p6_fetch_branch_ctrl #(
    parameter int          PC_W     = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic            N,
    input  logic            V,
    input  logic            Z,
    input  logic [15:0]     rd_val,
    input  logic            exec_done,
    output logic [1:0]      mem_cmd,
    output logic [PC_W-1:0] mem_addr,
    output logic            load_ir,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      readnum,
    output logic            link_write,
    output logic [2:0]      writenum,
    output logic [15:0]     link_data,
    output logic            exec_start,
    output logic            w,
    output logic            halted,
    output logic [3:0]      dbg_state_o
);

    typedef enum logic [3:0] {
        S_WAIT      = 4'd0,
        S_IF1       = 4'd1,
        S_IF2       = 4'd2,
        S_UPDATE_PC = 4'd3,
        S_DECODE    = 4'd4,
        S_BRANCH    = 4'd5,
        S_LINK      = 4'd6,
        S_BX        = 4'd7,
        S_EXEC      = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_READ = 2'b01;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;

    logic [2:0]        op;
    logic [1:0]        sub;
    logic [2:0]        cond;
    logic [15:0]       sx16;
    logic [PC_W-1:0]   sximm;
    logic [PC_W-1:0]   rd_pc;
    logic [15:0]       pc_ext;
    logic              taken;

    // Only the low PC_W bits of the register read form a jump target.
    logic              unused_rd;
    assign unused_rd = ^rd_val;

    assign op    = ir_q[15:13];
    assign sub   = ir_q[12:11];
    assign cond  = ir_q[10:8];
    assign sx16  = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm = sx16[PC_W-1:0];
    assign rd_pc = rd_val[PC_W-1:0];

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign dbg_state_o = state_q;

    // Zero-extend the PC for the R7 link value.
    always_comb begin
        pc_ext            = '0;
        pc_ext[PC_W-1:0]  = pc_q;
    end

    // Branch condition from the live datapath flags.
    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = ~Z;
            3'b011:  taken = N ^ V;
            3'b100:  taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

    // State, PC and instruction register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_WAIT;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC/IR updates and per-state outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_cmd    = MEM_NONE;
        load_ir    = 1'b0;
        readnum    = 3'd0;
        link_write = 1'b0;
        writenum   = 3'd0;
        link_data  = 16'd0;
        exec_start = 1'b0;
        w          = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_d = S_IF1;
            end
            S_IF1: begin
                mem_cmd = MEM_READ;
                state_d = S_IF2;
            end
            S_IF2: begin
                mem_cmd = MEM_READ;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    ir_d    = mem_rdata;
                    state_d = S_UPDATE_PC;
                end
            end
            S_UPDATE_PC: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    3'b001: state_d = S_BRANCH;
                    3'b010: begin
                        case (sub)
                            2'b11:   state_d = S_LINK;
                            2'b10:   state_d = S_LINK;
                            2'b00:   state_d = S_BX;
                            default: state_d = S_IF1;
                        endcase
                    end
                    3'b111: state_d = S_HALT;
                    default: begin
                        exec_start = 1'b1;
                        state_d    = S_EXEC;
                    end
                endcase
            end
            S_BRANCH: begin
                if (taken) pc_d = pc_q + sximm;
                state_d = S_IF1;
            end
            S_LINK: begin
                link_write = 1'b1;
                writenum   = 3'd7;
                link_data  = pc_ext;
                if (sub == 2'b10) begin
                    // BLX: the read sees R7 before this cycle's link write.
                    readnum = ir_q[7:5];
                    pc_d    = rd_pc;
                end else begin
                    pc_d    = pc_q + sximm;
                end
                state_d = S_IF1;
            end
            S_BX: begin
                readnum = ir_q[7:5];
                pc_d    = rd_pc;
                state_d = S_IF1;
            end
            S_EXEC: begin
                if (exec_done) state_d = S_IF1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        // An asserted reset suppresses every pulse in the cycle it is seen.
        if (!reset) begin
            load_ir    = 1'b0;
            exec_start = 1'b0;
            link_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_p6_fetch_branch_ctrl.sv
// Self-checking bench for p6_fetch_branch_ctrl: reset/start sequence,
// table of single-instruction vectors, randomized instructions checked
// against an instruction-level model, and halt / reset-in-fetch corners.
module tb_p6_fetch_branch_ctrl;

    localparam int PC_W = 9;
    localparam int PC_MOD = 1 << PC_W;

    logic            clk;
    logic            reset;
    logic            s;
    logic [15:0]     mem_rdata;
    logic            mem_ready;
    logic            N, V, Z;
    logic [15:0]     rd_val;
    logic            exec_done;
    logic [1:0]      mem_cmd;
    logic [PC_W-1:0] mem_addr;
    logic            load_ir;
    logic [15:0]     instruction;
    logic [PC_W-1:0] pc;
    logic [2:0]      readnum;
    logic            link_write;
    logic [2:0]      writenum;
    logic [15:0]     link_data;
    logic            exec_start;
    logic            w;
    logic            halted;
    logic [3:0]      dbg_state;

    logic [15:0]     regs [8];
    int              total = 0;
    int              bad   = 0;
    int              cur_pc;

    assign rd_val = regs[readnum];

    p6_fetch_branch_ctrl #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .s(s), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .N(N), .V(V), .Z(Z), .rd_val(rd_val),
        .exec_done(exec_done), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .load_ir(load_ir), .instruction(instruction), .pc(pc),
        .readnum(readnum), .link_write(link_write), .writenum(writenum),
        .link_data(link_data), .exec_start(exec_start), .w(w),
        .halted(halted), .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          next;
        bit          timeout;
        bit          halt;
        int          links;
        logic [15:0] ld;
        logic [2:0]  wn;
        int          execs;
        int          loads;
        int          lat;
    } obs_t;

    typedef struct {
        logic [15:0] word;
        int          pc0;
        bit          n;
        bit          v;
        bit          z;
        logic [15:0] rd;
        int          exp_next;
        int          exp_links;
        int          exp_ld;
        int          exp_exec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: entered in an IF1 cycle (already sampled). Serves the fetch
    // after 'delay' stall cycles, releases EXEC after 'exec_wait' cycles and
    // follows the DUT until the next IF1 or HALT. Inputs that the current
    // state must ignore are driven with random junk.
    task automatic do_instr(input logic [15:0] word, input int delay,
                            input int exec_wait, output obs_t o);
        bit exec_on = 0;
        int exec_cnt = 0;
        bit done = 0;
        o = '{next: -1, timeout: 0, halt: 0, links: 0, ld: 16'h0, wn: 3'd0,
              execs: 0, loads: 0, lat: -1};
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            s = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            @(negedge clk);
            if (load_ir) o.loads++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        mem_rdata = word;
        @(negedge clk);
        if (load_ir) o.loads++;
        @(posedge clk); #1;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_rdata = 16'($urandom);
            mem_ready = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if (exec_on) exec_done = (exec_cnt >= exec_wait);
            else         exec_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (load_ir) o.loads++;
            if (link_write) begin
                o.links++;
                o.ld = link_data;
                o.wn = writenum;
            end
            if (exec_start) begin
                o.execs++;
                exec_on = 1;
            end else if (exec_on) begin
                exec_cnt++;
            end
            if (halted) begin
                o.halt = 1;
                o.lat = c;
                done = 1;
            end else if (mem_cmd == 2'b01) begin
                o.next = int'(mem_addr);
                o.lat = c;
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) o.timeout = 1;
        exec_done = 1'b0;
    endtask

    // Instruction-level reference: what the program-visible result of one
    // instruction fetched at fpc should be.
    task automatic model(input logic [15:0] wd, input int fpc, input bit n,
                         input bit v, input bit z, input int exec_wait,
                         output int e_next, output int e_links, output int e_ld,
                         output int e_exec, output int e_halt, output int e_lat);
        int after = (fpc + 1) % PC_MOD;
        int imm = int'($signed(wd[7:0]));
        int rel = ((after + imm) % PC_MOD + PC_MOD) % PC_MOD;
        int rdv = int'(regs[wd[7:5]]) % PC_MOD;
        bit tk;
        e_next = after; e_links = 0; e_ld = 0; e_exec = 0; e_halt = 0; e_lat = 3;
        if (wd[15:13] == 3'b001) begin
            case (int'(wd[10:8]))
                0: tk = 1;
                1: tk = z;
                2: tk = !z;
                3: tk = (n != v);
                4: tk = (n != v) || z;
                default: tk = 0;
            endcase
            if (tk) e_next = rel;
        end else if (wd[15:13] == 3'b010) begin
            if (wd[12:11] == 2'b11) begin
                e_links = 1; e_ld = after; e_next = rel;
            end else if (wd[12:11] == 2'b10) begin
                e_links = 1; e_ld = after; e_next = rdv;
            end else if (wd[12:11] == 2'b00) begin
                e_next = rdv;
            end else begin
                e_lat = 2;
            end
        end else if (wd[15:13] == 3'b111) begin
            e_halt = 1; e_lat = 2;
        end else begin
            e_exec = 1; e_lat = exec_wait + 3;
        end
    endtask

    // Jump to an arbitrary PC with BX R2.
    task automatic set_pc(input int target);
        obs_t o;
        regs[2] = 16'(target);
        do_instr(16'h4040, $urandom_range(0, 2), 0, o);
        chk("setpc_next", o.next, target);
        cur_pc = o.next;
    endtask

    vec_t vecs[19];

    initial begin
        obs_t o;
        int e_next, e_links, e_ld, e_exec, e_halt, e_lat;
        logic [15:0] wd;

        vecs[0]  = '{16'h21FE,   5, 0, 0, 1, 16'h0000,   4, 0,  0, 0};
        vecs[1]  = '{16'h21FE,   5, 0, 0, 0, 16'h0000,   6, 0,  0, 0};
        vecs[2]  = '{16'h21FE, 511, 0, 0, 1, 16'h0000, 510, 0,  0, 0};
        vecs[3]  = '{16'h21FE, 511, 0, 0, 0, 16'h0000,   0, 0,  0, 0};
        vecs[4]  = '{16'h2303,  20, 1, 0, 0, 16'h0000,  24, 0,  0, 0};
        vecs[5]  = '{16'h2303,  20, 1, 1, 0, 16'h0000,  21, 0,  0, 0};
        vecs[6]  = '{16'h2403,  20, 0, 0, 1, 16'h0000,  24, 0,  0, 0};
        vecs[7]  = '{16'h2403,  20, 1, 1, 0, 16'h0000,  21, 0,  0, 0};
        vecs[8]  = '{16'h2403,  20, 1, 0, 0, 16'h0000,  24, 0,  0, 0};
        vecs[9]  = '{16'h2003,  30, 0, 0, 0, 16'h0000,  34, 0,  0, 0};
        vecs[10] = '{16'h2503,  30, 1, 0, 1, 16'h0000,  31, 0,  0, 0};
        vecs[11] = '{16'h5F04,  10, 0, 0, 0, 16'h0000,  15, 1, 11, 0};
        vecs[12] = '{16'h57E0,  10, 0, 0, 0, 16'h0020,  32, 1, 11, 0};
        vecs[13] = '{16'h4040,  40, 0, 0, 0, 16'h0033,  51, 0,  0, 0};
        vecs[14] = '{16'h4800,  50, 0, 0, 0, 16'h0000,  51, 0,  0, 0};
        vecs[15] = '{16'hA0E1,  60, 0, 0, 0, 16'h0000,  61, 0,  0, 1};
        vecs[16] = '{16'h2280, 100, 0, 0, 0, 16'h0000, 485, 0,  0, 0};
        vecs[17] = '{16'h2280, 100, 0, 0, 1, 16'h0000, 101, 0,  0, 0};
        vecs[18] = '{16'h5F80,   0, 0, 0, 0, 16'h0000, 385, 1,  1, 0};

        for (int i = 0; i < 8; i++) regs[i] = 16'h0100 + 16'(i);
        reset = 1'b0; s = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
        N = 1'b0; V = 1'b0; Z = 1'b0; exec_done = 1'b0;

        // Reset and start
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_w", w, 1);
        chk("rst_mem_cmd", mem_cmd, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_pulses", {load_ir, exec_start, link_write, halted}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("wait_idle_w", w, 1);
        @(posedge clk); #1;
        s = 1'b1;
        @(negedge clk);
        chk("wait_before_start", {w, mem_cmd}, 3'b100);
        @(posedge clk); #1;
        s = 1'b0;
        @(negedge clk);
        chk("start_mem_cmd", mem_cmd, 2'b01);
        chk("start_mem_addr", mem_addr, 0);
        chk("start_w", w, 0);
        cur_pc = 0;

        // Fetch stall of 3 cycles, execute handoff held for 5 cycles
        do_instr(16'hA0E1, 3, 5, o);
        chk("exec_loads", o.loads, 1);
        chk("exec_starts", o.execs, 1);
        chk("exec_latency", o.lat, 8);
        chk("exec_next", o.next, 1);
        chk("exec_instruction", instruction, 16'hA0E1);
        cur_pc = o.next;

        // Table-driven single-instruction vectors
        for (int i = 0; i < 19; i++) begin
            set_pc(vecs[i].pc0);
            regs[vecs[i].word[7:5]] = vecs[i].rd;
            N = vecs[i].n; V = vecs[i].v; Z = vecs[i].z;
            do_instr(vecs[i].word, $urandom_range(0, 3), $urandom_range(0, 3), o);
            chk($sformatf("vec%0d_next", i), o.next, vecs[i].exp_next);
            chk($sformatf("vec%0d_links", i), o.links, vecs[i].exp_links);
            chk($sformatf("vec%0d_exec", i), o.execs, vecs[i].exp_exec);
            if (vecs[i].exp_links != 0) begin
                chk($sformatf("vec%0d_link_data", i), o.ld, vecs[i].exp_ld);
                chk($sformatf("vec%0d_writenum", i), o.wn, 7);
            end
            cur_pc = o.next;
        end

        // Randomized instructions against the instruction-level model
        for (int k = 0; k < 80; k++) begin
            int cls = $urandom_range(0, 5);
            int dly = $urandom_range(0, 3);
            int ew = $urandom_range(0, 4);
            logic [2:0] op;
            case (cls)
                0: wd = {3'b001, 13'($urandom)};
                1: wd = {3'b010, 2'b11, 11'($urandom)};
                2: wd = {3'b010, 2'b10, 11'($urandom)};
                3: wd = {3'b010, 2'b00, 11'($urandom)};
                4: wd = {3'b010, 2'b01, 11'($urandom)};
                default: begin
                    op = 3'b001;
                    while (op == 3'b001 || op == 3'b010 || op == 3'b111)
                        op = 3'($urandom_range(0, 7));
                    wd = {op, 13'($urandom)};
                end
            endcase
            for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
            N = 1'($urandom_range(0, 1));
            V = 1'($urandom_range(0, 1));
            Z = 1'($urandom_range(0, 1));
            model(wd, cur_pc, N, V, Z, ew, e_next, e_links, e_ld, e_exec, e_halt, e_lat);
            do_instr(wd, dly, ew, o);
            chk($sformatf("rnd%0d_%h_next", k, wd), o.next, e_next);
            chk($sformatf("rnd%0d_%h_links", k, wd), o.links, e_links);
            chk($sformatf("rnd%0d_%h_exec", k, wd), o.execs, e_exec);
            chk($sformatf("rnd%0d_%h_loads", k, wd), o.loads, 1);
            chk($sformatf("rnd%0d_%h_lat", k, wd), o.lat, e_lat);
            if (e_links != 0) begin
                chk($sformatf("rnd%0d_%h_link_data", k, wd), o.ld, e_ld);
                chk($sformatf("rnd%0d_%h_writenum", k, wd), o.wn, 7);
            end
            if (o.next < 0) begin
                $display("FAIL rnd%0d lost sync: next fetch never seen", k);
                $display("test done: total=%0d bad=%0d", total, bad + 1);
                $fatal(1, "lost sync");
            end
            cur_pc = o.next;
        end

        // HALT ignores s, mem_ready and exec_done
        set_pc(77);
        do_instr(16'hE000, 1, 0, o);
        chk("halt_seen", o.halt, 1);
        chk("halt_latency", o.lat, 2);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            s = 1'(c & 1);
            mem_ready = 1'b1;
            exec_done = 1'(~c & 1);
            @(negedge clk);
            chk($sformatf("halt_hold%0d", c), {halted, w, mem_cmd, load_ir, exec_start}, 6'b100000);
        end

        // Reset while stalled in IF2
        @(posedge clk); #1;
        reset = 1'b0; s = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        @(negedge clk);
        chk("restart_fetch", {mem_cmd, mem_addr}, {2'b01, 9'd0});
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("if2_stall%0d", c), {mem_cmd, load_ir}, 3'b010);
            @(posedge clk); #1;
        end
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        chk("rst_overrides_load", load_ir, 0);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {w, mem_cmd, load_ir}, 4'b1000);
        chk("rst_mid_pc", pc, 0);
        chk("rst_mid_instruction", instruction, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_stays_wait", {w, load_ir}, 2'b10);

        $display("final debug state=%0d", dbg_state);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
